// File: rtl/otbn_pq_pkg.sv
// Shared types and constants for the PQ datapath helpers.
// Holds the bit-reverse opcode set and the permutation sequencer state encoding.
package otbn_pq_pkg;

    localparam int unsigned BitrevLog2NMin = 6;
    localparam int unsigned BitrevLog2NMax = 12;
    localparam int unsigned BitrevIdxW     = 12;

    typedef enum logic [1:0] {
        BitrevOpNone,
        BitrevOpPq,
        BitrevOpPqShift
    } bitrev_op_e;

    typedef enum logic [1:0] {
        BitrevPermIdle,
        BitrevPermScan,
        BitrevPermEmit,
        BitrevPermDone
    } bitrev_perm_state_e;

endpackage

// File: rtl/otbn_bitreverse.sv
// Combinational bit reversal of the low nof_bits of an index.
// The PqShift opcode additionally returns the result as a word byte offset.
module otbn_bitreverse
    import otbn_pq_pkg::*;
(
    input  logic [BitrevIdxW-1:0] operand,
    input  logic [3:0]            nof_bits,
    input  bitrev_op_e            op,
    output logic [31:0]           result
);

    logic [BitrevIdxW-1:0] rev_full;
    logic [BitrevIdxW-1:0] rev_low;

    always_comb begin
        for (int k = 0; k < int'(BitrevIdxW); k++) begin
            rev_full[k] = operand[BitrevIdxW-1-k];
        end
        // Reversing all 12 bits then shifting down aligns the low nof_bits reversal.
        rev_low = rev_full >> (4'd12 - nof_bits);
    end

    always_comb begin
        result = 32'd0;
        unique case (op)
            BitrevOpNone:    result = {20'd0, operand};
            BitrevOpPq:      result = {20'd0, rev_low};
            BitrevOpPqShift: result = {18'd0, rev_low, 2'd0};
            default:         result = 32'd0;
        endcase
    end

endmodule

// File: rtl/otbn_bitrev_perm_seq.sv
// Walks i = 0..N-1 and streams the (i, rev(i)) swap pairs with i < rev(i)
// for an in-place bit-reversal permutation, over a valid/ready handshake.
module otbn_bitrev_perm_seq
    import otbn_pq_pkg::*;
#(
    parameter int unsigned Log2NMin = BitrevLog2NMin,
    parameter int unsigned Log2NMax = BitrevLog2NMax
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        clear_i,
    input  logic [3:0]  log2n_i,
    input  logic        shift_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        pair_valid_o,
    input  logic        pair_ready_i,
    output logic [31:0] pair_idx_a_o,
    output logic [31:0] pair_idx_b_o
);

    bitrev_perm_state_e    state_q;
    logic [BitrevIdxW-1:0] idx_q;
    logic [3:0]            log2n_q;
    logic                  shift_q;

    bitrev_op_e            rev_op;
    logic [31:0]           rev_field;
    logic [31:0]           idx_field;
    logic [BitrevIdxW-1:0] idx_last;
    logic                  log2n_legal;

    assign rev_op      = shift_q ? BitrevOpPqShift : BitrevOpPq;
    assign idx_field   = shift_q ? {18'd0, idx_q, 2'd0} : {20'd0, idx_q};
    assign idx_last    = 12'((13'd1 << log2n_q) - 13'd1);
    assign log2n_legal = (32'(log2n_i) >= Log2NMin) && (32'(log2n_i) <= Log2NMax);

    otbn_bitreverse u_bitreverse (
        .operand  (idx_q),
        .nof_bits (log2n_q),
        .op       (rev_op),
        .result   (rev_field)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= BitrevPermIdle;
            idx_q        <= '0;
            log2n_q      <= '0;
            shift_q      <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            pair_valid_o <= 1'b0;
            pair_idx_a_o <= '0;
            pair_idx_b_o <= '0;
        end else if (clear_i) begin
            state_q      <= BitrevPermIdle;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            pair_valid_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            err_o  <= 1'b0;
            unique case (state_q)
                BitrevPermIdle: begin
                    if (start_i) begin
                        if (log2n_legal) begin
                            log2n_q <= log2n_i;
                            shift_q <= shift_i;
                            idx_q   <= '0;
                            busy_o  <= 1'b1;
                            state_q <= BitrevPermScan;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                BitrevPermScan: begin
                    // Both fields carry the same scaling, so comparing them preserves i < rev(i).
                    if (idx_field < rev_field) begin
                        pair_idx_a_o <= idx_field;
                        pair_idx_b_o <= rev_field;
                        pair_valid_o <= 1'b1;
                        state_q      <= BitrevPermEmit;
                    end else if (idx_q == idx_last) begin
                        done_o  <= 1'b1;
                        state_q <= BitrevPermDone;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                BitrevPermEmit: begin
                    if (pair_ready_i) begin
                        pair_valid_o <= 1'b0;
                        idx_q        <= idx_q + 1'b1;
                        state_q      <= BitrevPermScan;
                    end
                end
                BitrevPermDone: begin
                    busy_o  <= 1'b0;
                    state_q <= BitrevPermIdle;
                end
                default: state_q <= BitrevPermIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_otbn_bitrev_perm_seq.sv
// Self-checking bench for otbn_bitrev_perm_seq: table-driven passes against an
// arithmetic reversal model, plus hand-written error, clear and reset sequences.
module tb_otbn_bitrev_perm_seq;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        clear_i;
    logic [3:0]  log2n_i;
    logic        shift_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        pair_valid_o;
    logic        pair_ready_i;
    logic [31:0] pair_idx_a_o;
    logic [31:0] pair_idx_b_o;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned exp_a[$];
    int unsigned exp_b[$];

    typedef struct {
        int unsigned log2n;
        bit          shift;
        int unsigned ready_pct;
        bit          inject;
        int unsigned exp_pairs;
        int unsigned first_a;
        int unsigned first_b;
    } pass_vec_t;

    pass_vec_t vecs[7];
    int unsigned bad_log2n[4];

    otbn_bitrev_perm_seq dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .clear_i      (clear_i),
        .log2n_i      (log2n_i),
        .shift_i      (shift_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .pair_valid_o (pair_valid_o),
        .pair_ready_i (pair_ready_i),
        .pair_idx_a_o (pair_idx_a_o),
        .pair_idx_b_o (pair_idx_b_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got timeout/extra event, expected none", name);
    endtask

    function automatic int unsigned rev_bits(input int unsigned v, input int unsigned w);
        int unsigned r = 0;
        for (int k = 0; k < int'(w); k++) r = r * 2 + ((v >> k) & 1);
        return r;
    endfunction

    task automatic build_model(input int unsigned log2n, input bit shift);
        int unsigned n    = 1 << log2n;
        int unsigned mult = shift ? 4 : 1;
        exp_a.delete();
        exp_b.delete();
        for (int unsigned i = 0; i < n; i++) begin
            int unsigned r = rev_bits(i, log2n);
            if (i < r) begin
                exp_a.push_back(i * mult);
                exp_b.push_back(r * mult);
            end
        end
    endtask

    task automatic start_pass(input int unsigned log2n, input bit shift);
        @(negedge clk_i);
        start_i = 1'b1;
        log2n_i = 4'(log2n);
        shift_i = shift;
        @(negedge clk_i);
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1);
    endtask

    task automatic wait_valid(input string name);
        int cyc = 0;
        while (!pair_valid_o && cyc < 50) begin
            @(negedge clk_i);
            cyc++;
        end
        check(name, pair_valid_o, 1);
    endtask

    task automatic run_pass(input pass_vec_t v);
        int unsigned pidx = 0;
        int unsigned ha = 0, hb = 0;
        bit held = 0, done_seen = 0, err_seen = 0, finished = 0;
        int budget = 8 * (1 << v.log2n) + 200;
        build_model(v.log2n, v.shift);
        start_pass(v.log2n, v.shift);
        for (int cyc = 0; cyc < budget && !finished; cyc++) begin
            @(negedge clk_i);
            if (err_o) err_seen = 1;
            if (done_seen) begin
                check("busy_low_after_done", busy_o, 0);
                check("done_single_cycle", done_o, 0);
                finished = 1;
            end else if (done_o) begin
                done_seen = 1;
                check("pairs_at_done", pidx, v.exp_pairs);
                check("no_valid_at_done", pair_valid_o, 0);
            end
            if (pair_valid_o) begin
                if (pidx >= exp_a.size()) begin
                    fail_now("extra_pair");
                end else if (!held) begin
                    check("pair_a", pair_idx_a_o, exp_a[pidx]);
                    check("pair_b", pair_idx_b_o, exp_b[pidx]);
                    if (pidx == 0) begin
                        check("first_a", pair_idx_a_o, v.first_a);
                        check("first_b", pair_idx_b_o, v.first_b);
                    end
                    held = 1;
                    ha = pair_idx_a_o;
                    hb = pair_idx_b_o;
                end else begin
                    check("stall_a_stable", pair_idx_a_o, ha);
                    check("stall_b_stable", pair_idx_b_o, hb);
                end
            end
            if (v.inject && cyc == 20) begin
                start_i = 1'b1;
                log2n_i = 4'd5;
                shift_i = 1'b1;
            end else begin
                start_i = 1'b0;
            end
            pair_ready_i = ($urandom_range(99) < v.ready_pct);
            if (pair_valid_o && pair_ready_i) begin
                held = 0;
                pidx++;
            end
        end
        if (!finished) fail_now("pass_timeout");
        check("no_err_in_pass", err_seen, 0);
        start_i      = 1'b0;
        pair_ready_i = 1'b0;
    endtask

    initial begin
        rst_i        = 1'b1;
        start_i      = 1'b0;
        clear_i      = 1'b0;
        log2n_i      = 4'd0;
        shift_i      = 1'b0;
        pair_ready_i = 1'b0;

        vecs[0] = '{6,  1'b0, 100, 1'b0, 28,   1, 32};
        vecs[1] = '{12, 1'b1, 100, 1'b0, 2016, 4, 8192};
        vecs[2] = '{8,  1'b0, 50,  1'b0, 120,  1, 128};
        vecs[3] = '{7,  1'b1, 70,  1'b1, 56,   4, 256};
        vecs[4] = '{9,  1'b0, 30,  1'b0, 240,  1, 256};
        vecs[5] = '{10, 1'b1, 80,  1'b0, 496,  4, 2048};
        vecs[6] = '{11, 1'b0, 100, 1'b0, 992,  1, 1024};
        bad_log2n = '{5, 13, 0, 15};

        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_valid", pair_valid_o, 0);
        check("rst_a", pair_idx_a_o, 0);
        check("rst_b", pair_idx_b_o, 0);

        foreach (vecs[k]) run_pass(vecs[k]);

        // Illegal sizes: err pulse only, then a legal pass still works.
        foreach (bad_log2n[k]) begin
            @(negedge clk_i);
            start_i = 1'b1;
            log2n_i = 4'(bad_log2n[k]);
            @(negedge clk_i);
            start_i = 1'b0;
            check("err_pulse", err_o, 1);
            check("err_no_busy", busy_o, 0);
            @(negedge clk_i);
            check("err_one_cycle", err_o, 0);
            check("err_no_valid", pair_valid_o, 0);
            check("err_still_idle", busy_o, 0);
        end
        run_pass(vecs[0]);

        // Clear while a pair is stalled.
        start_pass(7, 1'b0);
        pair_ready_i = 1'b0;
        wait_valid("clr_valid_up");
        repeat (3) begin
            @(negedge clk_i);
            check("clr_hold_valid", pair_valid_o, 1);
            check("clr_hold_a", pair_idx_a_o, 1);
            check("clr_hold_b", pair_idx_b_o, 64);
        end
        clear_i = 1'b1;
        @(negedge clk_i);
        clear_i = 1'b0;
        check("clr_valid", pair_valid_o, 0);
        check("clr_busy", busy_o, 0);
        check("clr_done", done_o, 0);
        repeat (3) begin
            @(negedge clk_i);
            check("clr_no_done", done_o, 0);
            check("clr_stay_idle", busy_o, 0);
        end
        // Start arriving together with clear is dropped.
        clear_i = 1'b1;
        start_i = 1'b1;
        log2n_i = 4'd6;
        @(negedge clk_i);
        clear_i = 1'b0;
        start_i = 1'b0;
        check("clr_start_ignored", busy_o, 0);
        run_pass('{7, 1'b0, 100, 1'b0, 56, 1, 64});

        // Reset during EMIT.
        start_pass(8, 1'b0);
        pair_ready_i = 1'b0;
        wait_valid("rst_emit_valid_up");
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("rst_emit_busy", busy_o, 0);
        check("rst_emit_done", done_o, 0);
        check("rst_emit_err", err_o, 0);
        check("rst_emit_valid", pair_valid_o, 0);
        check("rst_emit_a", pair_idx_a_o, 0);
        check("rst_emit_b", pair_idx_b_o, 0);
        run_pass(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
